// File: rtl/rvv_alu_seq_if.sv
// Sequencer-to-ALU bus for one rvv_alu lane: control driven by the sequencer,
// per-chunk result and opcode support flag returned by the ALU.
interface rvv_alu_seq_if;
  logic       alu_run;
  logic [5:0] alu_opcode;
  logic [2:0] alu_vsew;
  logic [2:0] alu_op_type;
  logic [9:0] alu_byte_i;
  logic [3:0] alu_in_reg_offset;
  logic [63:0] alu_vd;
  logic [9:0] alu_index;
  logic       alu_instr_valid;

  modport master (
    output alu_run, alu_opcode, alu_vsew, alu_op_type, alu_byte_i, alu_in_reg_offset,
    input  alu_vd, alu_index, alu_instr_valid
  );

  modport slave (
    input  alu_run, alu_opcode, alu_vsew, alu_op_type, alu_byte_i, alu_in_reg_offset,
    output alu_vd, alu_index, alu_instr_valid
  );
endinterface

// File: rtl/rvv_alu_seq.sv
// Element/chunk sequencer driving one rvv_alu lane and assembling a VLEN-wide result.
// Optional RVV_SEQ_TAIL_AGNOSTIC_EN: accumulator preloads all ones instead of vd_old.
module rvv_alu_seq #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [5:0]      opcode_in,
  input  logic [2:0]      vsew_in,
  input  logic [2:0]      op_type_in,
  input  logic [7:0]      vl,
  input  logic [VLEN-1:0] vd_old,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [VLEN-1:0] vd_out,
  rvv_alu_seq_if.master   alu,
  output logic [1:0]      dbg_state
);
  // Handshake: start is a valid that is only accepted (implicit ready) in IDLE;
  // every accepted command ends in exactly one done pulse unless killed or reset.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         L  = 1 << LANE_WIDTH;
  localparam logic [3:0] LW = 4'(LANE_WIDTH);
  localparam logic [VLEN-1:0] LANE_ONES = {{(VLEN-L){1'b0}}, {L{1'b1}}};

  logic [1:0]      state;
  logic [5:0]      opcode_q;
  logic [2:0]      vsew_q;
  logic [2:0]      op_type_q;
  logic [7:0]      vl_q;
  logic [9:0]      elem;
  logic [3:0]      chunk;
  logic            run_q;
  logic            err_q;
  logic [VLEN-1:0] acc;

  logic [3:0]      sew_log;
  logic [3:0]      chunk_log;
  logic [3:0]      c_last;
  logic [31:0]     vlmax;
  logic            reject;
  logic            last_chunk;
  logic            last_elem;
  logic [VLEN-1:0] wmask;
  logic [VLEN-1:0] wdata;
  logic            unused_vd;

  assign sew_log    = 4'd3 + {1'b0, vsew_q};
  assign chunk_log  = (sew_log > LW) ? (sew_log - LW) : 4'd0;
  assign c_last     = (4'd1 << chunk_log) - 4'd1;
  assign vlmax      = 32'(VLEN) >> sew_log;
  assign reject     = (vsew_q > 3'd3) || ({24'd0, vl_q} > vlmax) || !alu.alu_instr_valid;
  assign last_chunk = (chunk == c_last);
  assign last_elem  = (elem == ({2'b00, vl_q} - 10'd1));

  // The ALU reports where its chunk belongs; min/max walk chunks MSB-first.
  assign wmask = LANE_ONES << alu.alu_index;
  assign wdata = VLEN'(alu.alu_vd[L-1:0]) << alu.alu_index;
  assign unused_vd = ^alu.alu_vd[63:L];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      opcode_q  <= '0;
      vsew_q    <= '0;
      op_type_q <= '0;
      vl_q      <= '0;
      elem      <= '0;
      chunk     <= '0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            opcode_q  <= opcode_in;
            vsew_q    <= vsew_in;
            op_type_q <= op_type_in;
            vl_q      <= vl;
`ifdef RVV_SEQ_TAIL_AGNOSTIC_EN
            acc       <= '1;
`else
            acc       <= vd_old;
`endif
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (kill) begin
            state <= S_IDLE;
          end else if (reject) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (vl_q == 8'd0) begin
            state <= S_DONE;
          end else begin
            elem  <= '0;
            chunk <= '0;
            run_q <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (kill) begin
            run_q <= 1'b0;
            elem  <= '0;
            chunk <= '0;
            state <= S_IDLE;
          end else begin
            acc <= (acc & ~wmask) | wdata;
            if (last_chunk) begin
              chunk <= '0;
              if (last_elem) begin
                run_q <= 1'b0;
                elem  <= '0;
                state <= S_DONE;
              end else begin
                elem <= elem + 10'd1;
              end
            end else begin
              chunk <= chunk + 4'd1;
            end
          end
        end
        default: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RVV_SEQ_TAIL_AGNOSTIC_EN
  logic unused_old;
  assign unused_old = ^vd_old;
`endif

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign err    = err_q;
  assign vd_out = acc;
  assign dbg_state = state;

  assign alu.alu_run           = run_q;
  assign alu.alu_opcode        = opcode_q;
  assign alu.alu_vsew          = vsew_q;
  assign alu.alu_op_type       = op_type_q;
  assign alu.alu_byte_i        = elem;
  assign alu.alu_in_reg_offset = chunk;
endmodule

// File: tb/tb_rvv_alu_seq.sv
// Randomized and directed bench for rvv_alu_seq with a behavioural ALU stub
// and a whole-vector reference model.
module tb_rvv_alu_seq;
  localparam int VLEN = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            kill;
  logic [5:0]      opcode_in;
  logic [2:0]      vsew_in;
  logic [2:0]      op_type_in;
  logic [7:0]      vl;
  logic [VLEN-1:0] vd_old;
  logic            busy;
  logic            done;
  logic            err;
  logic [VLEN-1:0] vd_out;
  logic [1:0]      dbg_state;

  rvv_alu_seq_if alu_bus ();

  rvv_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill),
    .opcode_in(opcode_in), .vsew_in(vsew_in), .op_type_in(op_type_in),
    .vl(vl), .vd_old(vd_old), .busy(busy), .done(done), .err(err),
    .vd_out(vd_out), .alu(alu_bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [63:0]     vs1_e [16];
  logic [63:0]     vs2_e [16];
  logic [VLEN-1:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'b000000, 6'b000010, 6'b001001, 6'b001010, 6'b001011, 6'b000100, 6'b000110};
  endfunction

  function automatic bit op_reversed(input logic [5:0] op);
    return op inside {6'b000100, 6'b000110};
  endfunction

  function automatic logic [63:0] alu_op(input logic [5:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int sew);
    logic [63:0] m, r;
    m = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
    a = a & m;
    b = b & m;
    case (op)
      6'b000000: r = a + b;
      6'b000010: r = a - b;
      6'b001001: r = a & b;
      6'b001010: r = a | b;
      6'b001011: r = a ^ b;
      6'b000100: r = (a < b) ? a : b;
      6'b000110: r = (a > b) ? a : b;
      default:   r = '0;
    endcase
    return r & m;
  endfunction

  // ALU stub: returns the requested chunk of the full element result.
  int          s_sew, s_c, s_pos;
  logic [63:0] s_r;
  always_comb begin
    s_sew = 8;
    s_c   = 1;
    s_pos = 0;
    s_r   = '0;
    alu_bus.alu_vd          = '0;
    alu_bus.alu_index       = '0;
    alu_bus.alu_instr_valid = op_known(alu_bus.alu_opcode);
    if (alu_bus.alu_vsew <= 3'd3 && alu_bus.alu_byte_i < 10'd16) begin
      s_sew = 8 << alu_bus.alu_vsew;
      s_c   = s_sew / 8;
      s_r   = alu_op(alu_bus.alu_opcode, vs2_e[alu_bus.alu_byte_i[3:0]],
                     vs1_e[alu_bus.alu_byte_i[3:0]], s_sew);
      s_pos = op_reversed(alu_bus.alu_opcode) ? (s_c - 1 - int'(alu_bus.alu_in_reg_offset))
                                              : int'(alu_bus.alu_in_reg_offset);
      alu_bus.alu_index = 10'(int'(alu_bus.alu_byte_i) * s_sew + s_pos * 8);
      alu_bus.alu_vd    = s_r >> (s_pos * 8);
    end
  end

  function automatic bit is_reject(input logic [5:0] op, input logic [2:0] vs, input logic [7:0] n);
    if (vs > 3'd3) return 1'b1;
    if (int'(n) > VLEN / (8 << vs)) return 1'b1;
    return !op_known(op);
  endfunction

  function automatic logic [VLEN-1:0] expected_vd(input logic [5:0] op, input logic [2:0] vs,
                                                  input logic [7:0] n, input logic [VLEN-1:0] base);
    logic [VLEN-1:0] e;
    logic [63:0]     r;
    int              sew;
    e = base;
    if (is_reject(op, vs, n)) return e;
    sew = 8 << vs;
    for (int i = 0; i < int'(n); i++) begin
      r = alu_op(op, vs2_e[i], vs1_e[i], sew);
      for (int b = 0; b < sew; b++) e[i*sew + b] = r[b];
    end
    return e;
  endfunction

  // Entered and left on a negedge in IDLE, so back-to-back calls exercise earliest restart.
  task automatic run_cmd(input logic [5:0] op, input logic [2:0] vs, input logic [2:0] ot,
                         input logic [7:0] n, input logic [VLEN-1:0] old);
    bit              rej, got_done;
    int              c, exp_lat, exp_runs, cycles, runs, mism;
    logic [VLEN-1:0] base;
`ifdef RVV_SEQ_TAIL_AGNOSTIC_EN
    base = '1;
`else
    base = old;
`endif
    rej      = is_reject(op, vs, n);
    c        = (vs <= 3'd3) ? (8 << vs) / 8 : 1;
    exp_runs = rej ? 0 : int'(n) * c;
    exp_lat  = 2 + exp_runs;
    exp_q.push_back(expected_vd(op, vs, n, base));
    opcode_in = op; vsew_in = vs; op_type_in = ot; vl = n; vd_old = old;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opcode_in = '0; vsew_in = '0; op_type_in = '0; vl = '0; vd_old = '0;
    cycles = 1; runs = 0; mism = 0; got_done = 1'b0;
    while (cycles <= 300) begin
      if (cycles == 1)
        check_eq("latch", VLEN'({alu_bus.alu_opcode, alu_bus.alu_vsew, alu_bus.alu_op_type}),
                 VLEN'({op, vs, ot}));
      if (alu_bus.alu_run) begin
        if (alu_bus.alu_byte_i != 10'(runs / c) || alu_bus.alu_in_reg_offset != 4'(runs % c)
            || !busy) mism++;
        runs++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
    check_eq("done_seen", VLEN'(got_done), VLEN'(1));
    if (got_done) begin
      check_eq("latency", VLEN'(cycles), VLEN'(exp_lat));
      check_eq("err", VLEN'(err), VLEN'(rej));
      check_eq("vd_out", vd_out, exp_q.pop_front());
      check_eq("run_cycles", VLEN'(runs), VLEN'(exp_runs));
      check_eq("sequence", VLEN'(mism), VLEN'(0));
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check_eq("idle_outs", VLEN'({busy, done, err, alu_bus.alu_run, alu_bus.alu_byte_i,
                                 alu_bus.alu_in_reg_offset}), VLEN'(0));
  endtask

  // Starts a 16-element vadd and aborts it on the 3rd RUN cycle by kill or reset.
  task automatic abort_cmd(input bit use_reset);
    int dones;
    for (int i = 0; i < 16; i++) begin
      vs1_e[i] = 64'($urandom);
      vs2_e[i] = 64'($urandom);
    end
    opcode_in = 6'b000000; vsew_in = 3'd0; op_type_in = 3'b001; vl = 8'd16;
    vd_old = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_in_run", VLEN'({busy, alu_bus.alu_run, alu_bus.alu_byte_i}), VLEN'({2'b11, 10'd2}));
    if (use_reset) begin
      reset = 1'b1;
      #1;
      check_eq("async_rst_ctl", VLEN'({busy, done, err, alu_bus.alu_run, alu_bus.alu_byte_i,
                                       alu_bus.alu_in_reg_offset, alu_bus.alu_opcode,
                                       alu_bus.alu_vsew, alu_bus.alu_op_type, dbg_state}), VLEN'(0));
      check_eq("async_rst_vd", vd_out, '0);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check_eq("kill_idle", VLEN'({busy, done, alu_bus.alu_run, dbg_state}), VLEN'(0));
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("no_done_abort", VLEN'(dones), VLEN'(0));
  endtask

  logic [5:0] ops [8];
  logic [2:0] ots [3];

  initial begin
    ops = '{6'b000000, 6'b000010, 6'b001001, 6'b001010, 6'b001011, 6'b000100, 6'b000110, 6'b111111};
    ots = '{3'b001, 3'b010, 3'b100};
    reset = 1'b1; start = 1'b0; kill = 1'b0;
    opcode_in = '0; vsew_in = '0; op_type_in = '0; vl = '0; vd_old = '0;
    for (int i = 0; i < 16; i++) begin vs1_e[i] = '0; vs2_e[i] = '0; end
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", VLEN'({busy, done, err, alu_bus.alu_run, alu_bus.alu_byte_i,
                                 alu_bus.alu_in_reg_offset, alu_bus.alu_opcode,
                                 alu_bus.alu_vsew, alu_bus.alu_op_type, dbg_state}), VLEN'(0));
    check_eq("reset_vd", vd_out, '0);
    reset = 1'b0;
    @(negedge clk);

    // vadd bytes: 0x10+i plus 1.
    for (int i = 0; i < 16; i++) begin vs1_e[i] = 64'h01; vs2_e[i] = 64'h10 + 64'(i); end
    run_cmd(6'b000000, 3'd0, 3'b001, 8'd16, {$urandom, $urandom, $urandom, $urandom});
    check_eq("tp1_bytes", VLEN'({vd_out[127:120], vd_out[7:0]}), VLEN'(16'h2011));

    // 32-bit carry across chunks.
    for (int i = 0; i < 16; i++) begin vs1_e[i] = 64'd1; vs2_e[i] = 64'h0000_00FF; end
    run_cmd(6'b000000, 3'd2, 3'b001, 8'd4, '0);
    check_eq("tp2_elem0", VLEN'(vd_out[31:0]), VLEN'(32'h0000_0100));

    // Unsigned max with reversed chunk order.
    for (int i = 0; i < 16; i++) begin vs1_e[i] = 64'h00FF; vs2_e[i] = 64'h0100; end
    run_cmd(6'b000110, 3'd1, 3'b001, 8'd8, '0);
    check_eq("tp3_elem7", VLEN'(vd_out[127:112]), VLEN'(16'h0100));

    // Tail handling.
    run_cmd(6'b001011, 3'd0, 3'b010, 8'd4, {16{8'hAA}});
`ifdef RVV_SEQ_TAIL_AGNOSTIC_EN
    check_eq("tail", VLEN'(vd_out[127:32]), VLEN'({12{8'hFF}}));
`else
    check_eq("tail", VLEN'(vd_out[127:32]), VLEN'({12{8'hAA}}));
`endif

    // Rejects and the empty command.
    run_cmd(6'b000000, 3'd0, 3'b001, 8'd17, {$urandom, $urandom, $urandom, $urandom});
    run_cmd(6'b111111, 3'd0, 3'b001, 8'd4, {$urandom, $urandom, $urandom, $urandom});
    run_cmd(6'b000000, 3'd5, 3'b100, 8'd1, {$urandom, $urandom, $urandom, $urandom});
    run_cmd(6'b000010, 3'd3, 3'b001, 8'd0, {$urandom, $urandom, $urandom, $urandom});

    // Aborts followed by a clean command.
    abort_cmd(1'b0);
    run_cmd(6'b000010, 3'd0, 3'b001, 8'd16, {$urandom, $urandom, $urandom, $urandom});
    abort_cmd(1'b1);
    run_cmd(6'b001010, 3'd1, 3'b001, 8'd8, {$urandom, $urandom, $urandom, $urandom});

    // Random commands.
    for (int t = 0; t < 30; t++) begin
      int         r, vlmax;
      logic [2:0] vs;
      logic [7:0] n;
      for (int i = 0; i < 16; i++) begin
        vs1_e[i] = {$urandom, $urandom};
        vs2_e[i] = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) vs1_e[i] = vs2_e[i];
      end
      r  = $urandom_range(0, 12);
      vs = (r < 12) ? 3'(r % 4) : 3'($urandom_range(4, 7));
      vlmax = (vs <= 3'd3) ? VLEN / (8 << vs) : 1;
      r = $urandom_range(0, 9);
      if (r == 0) n = 8'd0;
      else if (r == 1) n = 8'(vlmax + 1);
      else n = 8'($urandom_range(1, vlmax));
      run_cmd(ops[$urandom_range(0, 7)], vs, ots[$urandom_range(0, 2)], n,
              {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end
endmodule
